seq_detect_prog: RTL and testbench
==================================

# seq_detect_prog

Programmable serial bit-sequence detector. It is the parametrised successor to the team's fixed 1011 Mealy/Moore detectors. Pattern (1..MAX_LEN bits), overlap/non-overlap matching and Mealy/Moore output mode are loaded at run time, and a saturating match counter is kept. It sits on a serial input stream qualified by `en` and flags each pattern occurrence to downstream control logic.

## Interface
- `MAX_LEN`, default 8: maximum pattern length, at least 2. `LEN_W = $clog2(MAX_LEN+1)`.
- `CNT_W`, default 16: match counter width.
- `DEF_PATTERN`, default 8'b0000_1011: pattern after reset (MAX_LEN bits).
- `DEF_LEN`, default 4: pattern length after reset.
- `DEF_OVERLAP`, default 1: overlap mode after reset.
- `DEF_MOORE`, default 0: output mode after reset (0 = Mealy, 1 = Moore).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: `inp` valid this cycle.
- `inp` in 1: serial data bit.
- `cfg_load` in 1: latch `cfg_*` this cycle.
- `cfg_pattern` in MAX_LEN: pattern; bit `[len-1]` is received first, bit `[0]` last.
- `cfg_len` in LEN_W: pattern length; legal range 1..MAX_LEN.
- `cfg_overlap` in 1: 1 = overlapping matches allowed.
- `cfg_moore` in 1: 1 = registered Moore output, 0 = Mealy output.
- `count_clr` in 1: synchronous clear of `match_count`.
- `match` out 1: match indication.
- `match_count` out CNT_W: number of matches, saturating.
- `cfg_err` out 1: one-cycle pulse when `cfg_load` carries an illegal length.

## Operation
- **Internal state:**
  - history shift register `hist[MAX_LEN-1:0]`, newest bit at `[0]`;
  - fill counter `fill` (0..MAX_LEN, saturating): valid bits since the last clear;
  - active config registers `pat`, `len`, `ovl`, `moore`;
  - Moore output register.
- **Match condition (`hit`):** `en=1` and `fill >= len-1` and `{hist, inp}` low `len` bits equal `pat` low `len` bits. Bits above `len` are ignored.
- **On each clock edge with `en=1` and no `cfg_load`:**
  - `hist <= {hist[MAX_LEN-2:0], inp}`.
  - If `hit` and `ovl=0`, then `fill <= 0`. Otherwise `fill <= min(fill+1, MAX_LEN)`.
- **`en=0`:** history, fill and counter hold. `hit` is 0.
- **Mealy mode (`moore=0`):** `match = hit`, combinational, in the same cycle the final bit is presented.
- **Moore mode (`moore=1`):** `match` is the registered `hit`. It is high for exactly one cycle after the edge that sampled the final bit.
- **Counter:** `match_count` increments on every edge where `hit=1`, in both modes, and saturates at 2^CNT_W-1.
- **Counter priority:** if `count_clr` and `hit` occur on the same edge, `count_clr` wins and the counter becomes 0.
- **Config load, legal (`cfg_len` in 1..MAX_LEN):**
  - latch all `cfg_*` inputs;
  - clear `hist`, `fill` and the Moore output register;
  - the `inp` bit in that cycle is discarded and `hit` is forced to 0;
  - `match_count` is unaffected.
- **Config load, illegal (`cfg_len=0` or `cfg_len > MAX_LEN`):**
  - `cfg_err` pulses 1 on the next cycle;
  - active config, history and fill are unchanged;
  - the `inp` bit in that cycle is still discarded.
- **`len=1`:** every matching bit is a hit. Non-overlap behaves the same as overlap.

## Timing
- **Reset values:** `match=0`, `match_count=0`, `cfg_err=0`, `hist=0`, `fill=0`. Active config takes the `DEF_*` values.
- **Reset mid-stream:** partial history is lost and matching restarts from `fill=0`.
- **Latency:**
  - Mealy `match`: 0 cycles from the final bit.
  - Moore `match`: 1 cycle from the final bit.
  - `match_count`: updates at the edge sampling the final bit.
  - `cfg_err`: registered, 1 cycle after `cfg_load`.
- **New config:** takes effect for bits presented from the cycle after `cfg_load`.
- **Mode switch Moore→Mealy:** a pending Moore pulse is suppressed, because the register is cleared on load.
- **Throughput:** one bit per cycle. A back-to-back match on consecutive bits is legal, e.g. pattern `11` in overlap mode on input `111`.

## Test plan
- **Default 1011, Mealy, overlap:** input 1,0,1,1,0,1,1 with `en=1`.
  - `match` is high combinationally on bits 4 and 7.
  - `match_count=2`.
- **Same stream after `cfg_load` with overlap=0, len=4, pattern 1011:**
  - only bit 4 matches, `count=1`;
  - then 1,0,1,1 → match at bit 4 of that group, `count=2`.
- **Moore mode, pattern 110, len 3:** input 1,1,0,1,1,0.
  - `match` is high for one cycle after the edges sampling bits 3 and 6.
  - `match_count=2`.
- **`en` gaps:** input 1,0,(en=0 ×3),1,1 → single match on the last bit. The gap has no effect.
- **Illegal config:** `cfg_load` with `cfg_len=0`, then `cfg_len=MAX_LEN+1`.
  - `cfg_err` pulses each time.
  - Default 1011 detection still works.
- **Boundary events:**
  - preload `count_clr` and `hit` on the same edge → `count=0`;
  - CNT_W=2 with 5 matches → `count=3`;
  - `rst` asserted between bits 3 and 4 of 1011 → no match on the following bit.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-sequence detector: run-time pattern/length, overlap and
// Mealy/Moore output mode, with a saturating match counter.
module seq_detect_prog #(
    parameter int unsigned          MAX_LEN     = 8,
    parameter int unsigned          CNT_W       = 16,
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = 8'b0000_1011,
    parameter int unsigned          DEF_LEN     = 4,
    parameter bit                   DEF_OVERLAP = 1'b1,
    parameter bit                   DEF_MOORE   = 1'b0,
    localparam int unsigned         LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               inp,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cfg_moore,
    input  logic               count_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic               r_moore;
    logic               r_moore_q;
    logic [CNT_W-1:0]   r_count;
    logic               r_cfg_err;

    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W:0]     w_fill_p1;
    logic               w_fill_ok;
    logic               w_eq;
    logic               w_hit;
    logic               w_cfg_legal;

    // Window includes the bit presented this cycle so Mealy output needs no extra stage.
    assign w_window    = {r_hist[MAX_LEN-2:0], inp};
    assign w_mask      = ~({MAX_LEN{1'b1}} << r_len);
    assign w_fill_p1   = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
    assign w_fill_ok   = (w_fill_p1 >= {1'b0, r_len});
    assign w_eq        = (((w_window ^ r_pat) & w_mask) == '0);
    assign w_hit       = en && !cfg_load && w_fill_ok && w_eq;
    assign w_cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pat     <= DEF_PATTERN;
            r_len     <= LEN_W'(DEF_LEN);
            r_ovl     <= DEF_OVERLAP;
            r_moore   <= DEF_MOORE;
            r_moore_q <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_load && !w_cfg_legal;
            r_moore_q <= w_hit;
            if (cfg_load) begin
                if (w_cfg_legal) begin
                    r_pat     <= cfg_pattern;
                    r_len     <= cfg_len;
                    r_ovl     <= cfg_overlap;
                    r_moore   <= cfg_moore;
                    r_hist    <= '0;
                    r_fill    <= '0;
                    r_moore_q <= 1'b0;
                end
            end else if (en) begin
                r_hist <= w_window;
                if (w_hit && !r_ovl) begin
                    r_fill <= '0;
                end else if (r_fill != LEN_W'(MAX_LEN)) begin
                    r_fill <= r_fill + LEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (count_clr) begin
            r_count <= '0;
        end else if (w_hit && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign match       = r_moore ? r_moore_q : w_hit;
    assign match_count = r_count;
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed self-checking bench for seq_detect_prog; a second instance with a
// 2-bit counter covers saturation.
module tb_seq_detect_prog;

    logic        clk;
    logic        rst;
    logic        en;
    logic        inp;
    logic        cfg_load;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic        cfg_moore;
    logic        count_clr;
    logic        match;
    logic [15:0] match_count;
    logic        cfg_err;

    logic        en2;
    logic        inp2;
    logic        cfg_load2;
    logic        count_clr2;
    logic        match2;
    logic [1:0]  count2;
    logic        cfg_err2;

    int n_checks = 0;
    int n_pass   = 0;

    seq_detect_prog u_dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .inp         (inp),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_moore   (cfg_moore),
        .count_clr   (count_clr),
        .match       (match),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    seq_detect_prog #(.CNT_W(2)) u_dut2 (
        .clk         (clk),
        .rst         (rst),
        .en          (en2),
        .inp         (inp2),
        .cfg_load    (cfg_load2),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_moore   (cfg_moore),
        .count_clr   (count_clr2),
        .match       (match2),
        .match_count (count2),
        .cfg_err     (cfg_err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mealy: match is checked combinationally before the sampling edge.
    task automatic send_mealy(input logic b, input logic exp, input string tag);
        en = 1'b1;
        inp = b;
        #1;
        check(tag, {31'b0, match}, {31'b0, exp});
        tick();
        en = 1'b0;
    endtask

    // Moore: match is checked just after the sampling edge.
    task automatic send_moore(input logic b, input logic exp, input string tag);
        en = 1'b1;
        inp = b;
        tick();
        check(tag, {31'b0, match}, {31'b0, exp});
        en = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o, input logic m);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_moore   = m;
        cfg_load    = 1'b1;
        en          = 1'b1;
        inp         = 1'b1;
        tick();
        cfg_load    = 1'b0;
        en          = 1'b0;
    endtask

    initial begin
        logic [15:0] seq2;
        rst = 1'b1; en = 0; inp = 0; cfg_load = 0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 0; cfg_moore = 0; count_clr = 0;
        en2 = 0; inp2 = 0; cfg_load2 = 0; count_clr2 = 0;
        #12;
        rst = 1'b0;
        check("rst_match", {31'b0, match}, 32'd0);
        check("rst_count", {16'b0, match_count}, 32'd0);
        check("rst_cfg_err", {31'b0, cfg_err}, 32'd0);
        tick();

        // Default 1011 Mealy overlap
        send_mealy(1, 0, "t1_b1"); send_mealy(0, 0, "t1_b2"); send_mealy(1, 0, "t1_b3");
        send_mealy(1, 1, "t1_b4"); send_mealy(0, 0, "t1_b5"); send_mealy(1, 0, "t1_b6");
        send_mealy(1, 1, "t1_b7");
        check("t1_count", {16'b0, match_count}, 32'd2);

        // Non-overlap 1011
        load(8'b0000_1011, 4'd4, 1'b0, 1'b0);
        check("t2_load_err", {31'b0, cfg_err}, 32'd0);
        check("t2_count_kept", {16'b0, match_count}, 32'd2);
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        check("t2_count_clr", {16'b0, match_count}, 32'd0);
        send_mealy(1, 0, "t2_b1"); send_mealy(0, 0, "t2_b2"); send_mealy(1, 0, "t2_b3");
        send_mealy(1, 1, "t2_b4"); send_mealy(0, 0, "t2_b5"); send_mealy(1, 0, "t2_b6");
        send_mealy(1, 0, "t2_b7");
        check("t2_count1", {16'b0, match_count}, 32'd1);
        send_mealy(1, 0, "t2_g1"); send_mealy(0, 0, "t2_g2"); send_mealy(1, 0, "t2_g3");
        send_mealy(1, 1, "t2_g4");
        check("t2_count2", {16'b0, match_count}, 32'd2);

        // Moore 110
        load(8'b0000_0110, 4'd3, 1'b1, 1'b1);
        send_moore(1, 0, "t3_b1"); send_moore(1, 0, "t3_b2");
        en = 1'b1; inp = 1'b0; #1;
        check("t3_not_comb", {31'b0, match}, 32'd0);
        tick(); en = 1'b0;
        check("t3_b3", {31'b0, match}, 32'd1);
        send_moore(1, 0, "t3_b4"); send_moore(1, 0, "t3_b5"); send_moore(0, 1, "t3_b6");
        check("t3_count", {16'b0, match_count}, 32'd4);
        tick();
        check("t3_one_cycle", {31'b0, match}, 32'd0);

        // Back to default Mealy; en gaps
        load(8'b0000_1011, 4'd4, 1'b1, 1'b0);
        send_mealy(1, 0, "t4_b1"); send_mealy(0, 0, "t4_b2");
        for (int i = 0; i < 3; i++) begin
            en = 1'b0; inp = 1'b1; #1;
            check("t4_gap", {31'b0, match}, 32'd0);
            tick();
        end
        send_mealy(1, 0, "t4_b3"); send_mealy(1, 1, "t4_b4");
        check("t4_count", {16'b0, match_count}, 32'd5);

        // Illegal configs leave 1011 detection intact
        load(8'hFF, 4'd0, 1'b0, 1'b1);
        check("t5_err_len0", {31'b0, cfg_err}, 32'd1);
        tick();
        check("t5_err_clear", {31'b0, cfg_err}, 32'd0);
        load(8'hFF, 4'd9, 1'b0, 1'b1);
        check("t5_err_len9", {31'b0, cfg_err}, 32'd1);
        send_mealy(1, 0, "t5_b1"); send_mealy(0, 0, "t5_b2"); send_mealy(1, 0, "t5_b3");
        send_mealy(1, 1, "t5_b4");
        check("t5_count", {16'b0, match_count}, 32'd6);

        // count_clr and hit on the same edge
        send_mealy(0, 0, "t6_b1"); send_mealy(1, 0, "t6_b2");
        count_clr = 1'b1;
        send_mealy(1, 1, "t6_b3");
        count_clr = 1'b0;
        check("t6_clr_wins", {16'b0, match_count}, 32'd0);

        // Reset between bits 3 and 4
        send_mealy(1, 0, "t7_b1"); send_mealy(1, 0, "t7_b2");
        send_mealy(1, 0, "t7_b3"); send_mealy(0, 0, "t7_b4"); send_mealy(1, 0, "t7_b5");
        rst = 1'b1; #2; rst = 1'b0;
        send_mealy(1, 0, "t7_after_rst");
        check("t7_count", {16'b0, match_count}, 32'd0);

        // len=1 non-overlap, then 11 back-to-back, then full-length pattern
        load(8'b0000_0001, 4'd1, 1'b0, 1'b0);
        send_mealy(1, 1, "t8_l1_b1"); send_mealy(1, 1, "t8_l1_b2");
        send_mealy(0, 0, "t8_l1_b3"); send_mealy(1, 1, "t8_l1_b4");
        load(8'b0000_0011, 4'd2, 1'b1, 1'b0);
        send_mealy(1, 0, "t8_11_b1"); send_mealy(1, 1, "t8_11_b2"); send_mealy(1, 1, "t8_11_b3");
        load(8'b1010_1010, 4'd8, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) send_mealy(((i % 2) == 0), 0, "t8_l8_pre");
        send_mealy(0, 1, "t8_l8_b8");
        send_mealy(1, 0, "t8_l8_b9"); send_mealy(0, 1, "t8_l8_b10");
        check("t8_count", {16'b0, match_count}, 32'd7);

        // CNT_W=2 saturation: 1011 overlapping five times
        seq2 = 16'b1011_0110_1101_1011;
        for (int i = 0; i < 16; i++) begin
            en2 = 1'b1; inp2 = seq2[15-i];
            tick();
            if (i == 9) check("t9_count3", {30'b0, count2}, 32'd3);
        end
        en2 = 1'b0;
        check("t9_saturated", {30'b0, count2}, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
